// File: rtl/pr_ctx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pr_ctx -- multi-bank P-R register unit with save/restore sequencer
//
// Holds NCTX banks of NREGS registers, WIDTH bits each. Register 0 of every
// bank is the flag register R0. One bank is active at a time. The CPU reads
// it on bus L and writes it from bus W. A small sequencer can spill the active
// bank to system memory, or fill it from memory, over a req/ack handshake.
//
// Ports
//   clk_sys      system clock
//   clm          master clear, synchronous, active-high
//   w/addr/we    write w into register addr of the active bank
//   blr          forces bus L to zero
//   l            active bank[addr], combinational
//   r0           R0 of the active bank
//   flag_we      masked R0 update: R0 = (R0 & ~flag_mask) | (flag_val & flag_mask)
//   ctx_we       load the active bank number from ctx_in
//   ctx          active bank number
//   cmd_save     spill the active bank to memory at base..base+NREGS-1
//   cmd_restore  fill the active bank from memory at base..base+NREGS-1
//   busy/done    sequencer running / one-cycle end-of-sequence pulse
//   mem_*        memory request port (mem_we=1 for save, 0 for restore)
// -----------------------------------------------------------------------------
module pr_ctx #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int NCTX  = 4,
  parameter int AW    = 16,
  localparam int RW   = $clog2(NREGS),
  localparam int CW   = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic             clk_sys,
  input  logic             clm,
  input  logic [WIDTH-1:0] w,
  input  logic [RW-1:0]    addr,
  input  logic             we,
  input  logic             blr,
  output logic [WIDTH-1:0] l,
  output logic [WIDTH-1:0] r0,
  input  logic             flag_we,
  input  logic [WIDTH-1:0] flag_mask,
  input  logic [WIDTH-1:0] flag_val,
  input  logic             ctx_we,
  input  logic [CW-1:0]    ctx_in,
  output logic [CW-1:0]    ctx,
  input  logic             cmd_save,
  input  logic             cmd_restore,
  input  logic [AW-1:0]    base,
  output logic             busy,
  output logic             done,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RESTORE,
    ST_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bank [NCTX][NREGS];
  logic [RW-1:0]    idx;
  logic [WIDTH-1:0] flag_merge;

  // Read side: everything the datapath sees is taken straight from the
  // active bank, so a bank switch shows up the cycle after ctx_we.
  // mem_wdata can be combinational because nothing writes the bank while a
  // save is running, so it is stable through memory wait states.
  assign l          = blr ? '0 : bank[ctx][addr];
  assign r0         = bank[ctx][0];
  assign mem_wdata  = bank[ctx][idx];
  assign flag_merge = (bank[ctx][0] & ~flag_mask) | (flag_val & flag_mask);

  // Storage, bank select and sequencer share one clocked block so that the
  // register array has a single writer. In IDLE the CPU owns the bank; in
  // SAVE/RESTORE only the sequencer may touch it. A full write to R0 beats a
  // same-cycle flag update. mem_addr is kept as a running base+index so it
  // wraps naturally at 2^AW. The sequence works on the post-edge ctx, since a
  // command issued together with ctx_we starts with the new bank already
  // selected.
  always_ff @(posedge clk_sys) begin
    if (clm) begin
      for (int b = 0; b < NCTX; b++) begin
        for (int r = 0; r < NREGS; r++) begin
          bank[b][r] <= '0;
        end
      end
      ctx      <= '0;
      state    <= ST_IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flag_we && !(we && addr == '0)) begin
            bank[ctx][0] <= flag_merge;
          end
          if (we) begin
            bank[ctx][addr] <= w;
          end
          if (ctx_we) begin
            ctx <= ctx_in;
          end
          if (cmd_save || cmd_restore) begin
            state    <= cmd_save ? ST_SAVE : ST_RESTORE;
            idx      <= '0;
            mem_addr <= base;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= cmd_save;
          end
        end

        ST_SAVE, ST_RESTORE: begin
          if (mem_ack) begin
            if (state == ST_RESTORE) begin
              bank[ctx][idx] <= mem_rdata;
            end
            if (idx == RW'(NREGS - 1)) begin
              state   <= ST_DONE;
              busy    <= 1'b0;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx      <= idx + RW'(1);
              mem_addr <= mem_addr + AW'(1);
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pr_ctx.md
Name: pr_ctx

Overview:
- Parametrised successor of the P-R register unit: holds NCTX on-chip banks of NREGS general registers, WIDTH bits each.
- Register 0 of every bank is the flag register (R0); registers 1..NREGS-1 are user registers.
- Switching the active bank takes one cycle. A save/restore sequencer spills or fills the active bank to or from system memory over a req/ack port.
- Sits between bus W (writes) and bus L (reads) in the CPU datapath, replacing the fixed single-bank unit.

Parameters:
WIDTH, 16, register and bus width
NREGS, 8, registers per bank including R0; power of two, >=2
NCTX, 4, number of banks; power of two, >=1
AW, 16, memory address width

Ports:
clk_sys  in  1  system clock
clm  in  1  master clear; synchronous, active-high reset
w  in  WIDTH  bus W write data
addr  in  log2(NREGS)  register select; 0 = R0
we  in  1  write w into addr of the active bank
blr  in  1  block registers: forces l to 0
l  out  WIDTH  bus L: active bank[addr], combinational
r0  out  WIDTH  R0 of the active bank
flag_we  in  1  R0 flag update strobe
flag_mask  in  WIDTH  R0 bits to update
flag_val  in  WIDTH  new values for masked bits
ctx_we  in  1  load active bank select
ctx_in  in  log2(NCTX)  new bank number
ctx  out  log2(NCTX)  active bank
cmd_save  in  1  start spill of the active bank
cmd_restore  in  1  start fill of the active bank
base  in  AW  memory base address; sampled with the command
busy  out  1  sequencer active
done  out  1  one-cycle pulse at sequence end
mem_req  out  1  memory request
mem_we  out  1  1 = write (save), 0 = read (restore)
mem_addr  out  AW  base + index, modulo 2^AW
mem_wdata  out  WIDTH  register being saved
mem_rdata  in  WIDTH  data returned for restore
mem_ack  in  1  completes the current request

Behaviour:
- Reset (clm=1 at a clock edge):
  - All registers of all banks are cleared to 0; ctx=0.
  - Sequencer goes to IDLE; busy=done=mem_req=mem_we=0; mem_addr=0.
  - Reset takes priority over every other input, including mid-sequence: an in-flight request is abandoned, and mem_req is 0 in the cycle after the reset edge.
- Read path:
  - l = 0 when blr=1; otherwise l = bank[ctx][addr], zero latency.
  - r0 = bank[ctx][0] at all times.
- Write path (IDLE only): we=1 writes w into bank[ctx][addr] at the clock edge. While busy=1, we, flag_we, ctx_we and new commands are ignored.
- Flag update: flag_we=1 sets R0 <= (R0 & ~flag_mask) | (flag_val & flag_mask). If we=1 with addr=0 in the same cycle, the full write wins and the flag update is dropped.
- Bank switch: ctx_we=1 sets ctx <= ctx_in at the edge. Same-cycle we or flag_we target the old bank, and the new bank is visible on l and r0 the following cycle.
- Sequencer states:
  - IDLE:
    - cmd_save -> SAVE; cmd_restore -> RESTORE; both asserted -> SAVE.
    - Entering either state latches base and sets index i=0.
    - we/flag_we/ctx_we in the same cycle as a command are still applied. The sequence operates on the post-edge ctx.
  - SAVE:
    - busy=1, mem_req=1, mem_we=1, mem_addr=base+i, mem_wdata=bank[ctx][i].
    - A cycle with mem_ack=1 completes item i: if i=NREGS-1 -> DONE, else i++.
    - mem_req stays high between items.
  - RESTORE:
    - Same handshake with mem_we=0.
    - On mem_ack, mem_rdata is written into bank[ctx][i] at that edge.
    - R0 is restored like any other register.
  - DONE: one cycle, done=1, busy=0, mem_req=0 -> IDLE.
- Timing: minimum sequence is NREGS cycles with mem_ack tied high, plus one DONE cycle. Wait states (mem_ack=0) hold all mem_* outputs stable.
- mem_ack while mem_req=0 is ignored.
- Address wrap: base + i is computed modulo 2^AW, e.g. base=16'hFFFE gives mem_addr FFFE, FFFF, 0000, ...
- Inactive banks are never modified by any operation.

Test Plan:
- Reset then read: clm=1 for 1 cycle; for each bank, addr 0..7 -> l=0, r0=0, ctx=0, mem_req=0.
- Bank isolation: write 16'h1234 to bank0 R3, ctx_we ctx_in=2, write 16'hABCD to R3 -> l=ABCD in bank2; switch back -> l=1234; blr=1 -> l=0.
- Flag merge and priority: R0=16'h00FF, flag_we with mask=16'h0F0F, val=16'hAAAA -> R0=16'h0AFA. Repeat with we=1, addr=0, w=16'h5555 in the same cycle -> R0=16'h5555.
- Save with wait states and wrap: bank1 R0..R7 = 16'h1000+i, base=16'hFFFE, ack every 2nd cycle -> 8 writes at FFFE, FFFF, 0000..0005 with data 1000..1007; outputs stable during waits; done pulses once; we during busy has no effect.
- Restore: memory at 16'h0100..0107 = 16'hC000+i, cmd_restore on bank3 with ack tied high -> busy for 8 cycles, then done; bank3 Ri = C000+i; banks 0..2 unchanged.
- Abort: clm asserted after 3 acks of a restore -> mem_req=0 next cycle, state IDLE, all banks 0; a new cmd_save afterwards runs a full 8-item sequence.
